// File: rtl/inv_pair_calibrator.sv
// Closed-loop strength calibrator for one up/down inverter pair: tunes the PMOS codes, then the
// NMOS codes, stepping on comparator polarity until enough reversals declare lock.
module inv_pair_calibrator #(
   parameter int CONF_BITS     = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int LOCK_FLIPS    = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 O_INVU,
   input  logic                 O_INVD,
   output logic [CONF_BITS-1:0] INVU_PCONF,
   output logic [CONF_BITS-1:0] INVU_NCONF,
   output logic [CONF_BITS-1:0] INVD_PCONF,
   output logic [CONF_BITS-1:0] INVD_NCONF,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 FAIL,
   output logic                 P_SAT,
   output logic                 N_SAT,
   output logic [2:0]           STATE
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FLIPS + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CAL_P = 3'd1,
      ST_CAL_N = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAIL  = 3'd4
   } state_t;

   state_t                state, next_state;
   logic [SW-1:0]         settle_cnt;
   logic [FW-1:0]         flip_cnt, flips_next;
   logic                  last_valid, last_pol;
   logic [CONF_BITS-1:0]  up_p, up_n, cur_up;
   logic                  p_sat, n_sat;
   logic                  busy_state, sample, valid, pol, flip;
   logic                  lock, at_limit, sat, step;

   // Only the up codes are stored; the down codes are their bitwise inverse by construction.
   assign INVU_PCONF = up_p;
   assign INVU_NCONF = up_n;
   assign INVD_PCONF = ~up_p;
   assign INVD_NCONF = ~up_n;
   assign P_SAT      = p_sat;
   assign N_SAT      = n_sat;

   assign busy_state = (state == ST_CAL_P) || (state == ST_CAL_N);
   assign sample     = busy_state && (settle_cnt == '0);
   assign valid      = O_INVU ^ O_INVD;
   assign pol        = O_INVU;
   assign flip       = valid && last_valid && (pol != last_pol);
   assign flips_next = flip_cnt + FW'(flip);
   assign cur_up     = (state == ST_CAL_N) ? up_n : up_p;
   assign at_limit   = pol ? (cur_up == '0) : (cur_up == '1);
   assign lock       = sample && valid && (flips_next == FW'(LOCK_FLIPS));
   assign sat        = sample && valid && !lock && at_limit;
   assign step       = sample && valid && !lock && !at_limit;

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (RST) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      // NOTE: default first so no path leaves next_state unassigned and infers a latch.
      next_state = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_FAIL: if (START) next_state = ST_CAL_P;
         ST_CAL_P: if (lock || sat) next_state = ST_CAL_N;
         ST_CAL_N: begin
            if (lock)     next_state = ST_DONE;
            else if (sat) next_state = ST_FAIL;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      STATE = state;
      BUSY  = busy_state;
      DONE  = (state == ST_DONE);
      FAIL  = (state == ST_FAIL);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         up_p       <= '1;
         up_n       <= '1;
         p_sat      <= 1'b0;
         n_sat      <= 1'b0;
         settle_cnt <= '0;
         flip_cnt   <= '0;
         last_valid <= 1'b0;
         last_pol   <= 1'b0;
      end else if (START && !busy_state) begin
         up_p       <= '1;
         up_n       <= '1;
         p_sat      <= 1'b0;
         n_sat      <= 1'b0;
         settle_cnt <= SW'(SETTLE_CYCLES);
         flip_cnt   <= '0;
         last_valid <= 1'b0;
      end else if (sample) begin
         settle_cnt <= SW'(SETTLE_CYCLES);
         if (lock || sat) begin
            // Phase ends: the next phase starts with fresh flip history.
            flip_cnt   <= '0;
            last_valid <= 1'b0;
            if (sat && state == ST_CAL_P) p_sat <= 1'b1;
            if (sat && state == ST_CAL_N) n_sat <= 1'b1;
         end else if (step) begin
            flip_cnt   <= flips_next;
            last_pol   <= pol;
            last_valid <= 1'b1;
            if (state == ST_CAL_P) up_p <= pol ? up_p - 1'b1 : up_p + 1'b1;
            else                   up_n <= pol ? up_n - 1'b1 : up_n + 1'b1;
         end
      end else if (busy_state) begin
         settle_cnt <= settle_cnt - SW'(1);
      end
   end

endmodule

// File: tb/tb_inv_pair_calibrator.sv
// Bench for inv_pair_calibrator: directed scenarios plus a randomized run against a
// cycle-level reference model built from phase age and polarity history.
module tb_inv_pair_calibrator;
   localparam int CB = 4;
   localparam int S  = 2;
   localparam int L  = 3;
   localparam int P  = S + 1;

   logic          CLK = 1'b0;
   logic          RST, START, O_INVU, O_INVD;
   logic [CB-1:0] INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF;
   logic          BUSY, DONE, FAIL, P_SAT, N_SAT;
   logic [2:0]    STATE;

   int total = 0;
   int bad   = 0;

   // Reference model: state, stored up codes, sticky flags, cycles since phase entry,
   // and the list of valid polarities seen in the current phase.
   int m_state = 0;
   int m_up_p  = 15;
   int m_up_n  = 15;
   int m_age   = 0;
   bit m_p_sat = 0;
   bit m_n_sat = 0;
   bit m_hist[$];

   always #5 CLK = ~CLK;

   inv_pair_calibrator #(.CONF_BITS(CB), .SETTLE_CYCLES(S), .LOCK_FLIPS(L)) dut (
      .CLK(CLK), .RST(RST), .START(START), .O_INVU(O_INVU), .O_INVD(O_INVD),
      .INVU_PCONF(INVU_PCONF), .INVU_NCONF(INVU_NCONF),
      .INVD_PCONF(INVD_PCONF), .INVD_NCONF(INVD_NCONF),
      .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .P_SAT(P_SAT), .N_SAT(N_SAT), .STATE(STATE)
   );

   task automatic end_phase(input bit saturated);
      if (m_state == 1) begin
         if (saturated) m_p_sat = 1;
         m_state = 2;
      end else begin
         if (saturated) m_n_sat = 1;
         m_state = saturated ? 4 : 3;
      end
      m_age = 0;
      m_hist.delete();
   endtask

   task automatic model_edge(input bit r, input bit s, input bit u, input bit d);
      int flips;
      int code;
      int nc;
      if (r) begin
         m_state = 0; m_up_p = 15; m_up_n = 15; m_p_sat = 0; m_n_sat = 0;
         m_age = 0; m_hist.delete();
      end else if (m_state == 0 || m_state == 3 || m_state == 4) begin
         if (s) begin
            m_state = 1; m_up_p = 15; m_up_n = 15; m_p_sat = 0; m_n_sat = 0;
            m_age = 0; m_hist.delete();
         end
      end else begin
         if ((m_age % P) == S && u != d) begin
            flips = 0;
            for (int i = 1; i < m_hist.size(); i++) if (m_hist[i] != m_hist[i-1]) flips++;
            if (m_hist.size() > 0 && m_hist[m_hist.size()-1] != u) flips++;
            code = (m_state == 1) ? m_up_p : m_up_n;
            nc   = u ? code - 1 : code + 1;
            if (flips >= L)             end_phase(0);
            else if (nc < 0 || nc > 15) end_phase(1);
            else begin
               if (m_state == 1) m_up_p = nc; else m_up_n = nc;
               m_hist.push_back(u);
               m_age++;
            end
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic clk_step(input bit r, input bit s, input bit u, input bit d);
      RST = r; START = s; O_INVU = u; O_INVD = d;
      model_edge(r, s, u, d);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      clk_step(1, 0, 0, 0);
      total++;
      if ({INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF} !== 16'hFF00) begin
         bad++; $display("FAIL reset_codes got=%h want=ff00",
                         {INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF});
      end
      total++;
      if ({STATE, BUSY, DONE, FAIL, P_SAT, N_SAT} !== 8'h00) begin
         bad++; $display("FAIL reset_status got=%h want=00", {STATE, BUSY, DONE, FAIL, P_SAT, N_SAT});
      end
   endtask

   task automatic test_p_saturation();
      int exp_code;
      clk_step(0, 1, 1, 0);
      total++;
      if (STATE !== 3'd1 || BUSY !== 1'b1) begin
         bad++; $display("FAIL psat_start state=%0d busy=%b want 1/1", STATE, BUSY);
      end
      for (int i = 1; i <= 16; i++) begin
         for (int j = 0; j < P; j++) begin
            clk_step(0, 0, 1, 0);
            exp_code = (i == 16) ? 0 : ((j == P - 1) ? 15 - i : 16 - i);
            total++;
            if (INVU_PCONF !== 4'(exp_code) || INVD_PCONF !== ~INVU_PCONF) begin
               bad++; $display("FAIL psat_step%0d_%0d up=%0d dn=%0d want up=%0d dn=%0d",
                               i, j, INVU_PCONF, INVD_PCONF, exp_code, 15 - exp_code);
            end
         end
      end
      total++;
      if (P_SAT !== 1'b1 || STATE !== 3'd2 || INVU_PCONF !== 4'h0 || INVD_PCONF !== 4'hF) begin
         bad++; $display("FAIL psat_end p_sat=%b state=%0d up=%0d dn=%0d want 1/2/0/15",
                         P_SAT, STATE, INVU_PCONF, INVD_PCONF);
      end
   endtask

   task automatic test_lock();
      bit [1:0] pat[4];
      int expc[4];
      int exps[4];
      pat  = '{2'b10, 2'b01, 2'b10, 2'b01};
      expc = '{14, 15, 14, 14};
      exps = '{1, 1, 1, 2};
      clk_step(1, 0, 0, 0);
      clk_step(0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         repeat (P) clk_step(0, 0, pat[k][1], pat[k][0]);
         total++;
         if (INVU_PCONF !== 4'(expc[k]) || INVD_PCONF !== ~4'(expc[k]) || STATE !== 3'(exps[k])) begin
            bad++; $display("FAIL lockp_%0d up=%0d dn=%0d state=%0d want up=%0d state=%0d",
                            k, INVU_PCONF, INVD_PCONF, STATE, expc[k], exps[k]);
         end
      end
      total++;
      if (P_SAT !== 1'b0) begin
         bad++; $display("FAIL lockp_psat got=%b want=0", P_SAT);
      end
      exps = '{2, 2, 2, 3};
      for (int k = 0; k < 4; k++) begin
         repeat (P) clk_step(0, 0, pat[k][1], pat[k][0]);
         total++;
         if (INVU_NCONF !== 4'(expc[k]) || INVD_NCONF !== ~4'(expc[k]) || STATE !== 3'(exps[k])) begin
            bad++; $display("FAIL lockn_%0d up=%0d dn=%0d state=%0d want up=%0d state=%0d",
                            k, INVU_NCONF, INVD_NCONF, STATE, expc[k], exps[k]);
         end
      end
      total++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || INVU_PCONF !== 4'd14 || N_SAT !== 1'b0) begin
         bad++; $display("FAIL lock_done done=%b busy=%b up_p=%0d n_sat=%b want 1/0/14/0",
                         DONE, BUSY, INVU_PCONF, N_SAT);
      end
   endtask

   task automatic test_invalid();
      bit [1:0] pat[6];
      int expc[6];
      int exps[6];
      pat  = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
      expc = '{14, 14, 14, 15, 14, 14};
      exps = '{1, 1, 1, 1, 1, 2};
      clk_step(0, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
         repeat (P) clk_step(0, 0, pat[k][1], pat[k][0]);
         total++;
         if (INVU_PCONF !== 4'(expc[k]) || STATE !== 3'(exps[k])) begin
            bad++; $display("FAIL invalid_%0d up=%0d state=%0d want up=%0d state=%0d",
                            k, INVU_PCONF, STATE, expc[k], exps[k]);
         end
      end
   endtask

   task automatic test_n_saturation();
      repeat (P) clk_step(0, 0, 0, 1);
      total++;
      if ({N_SAT, FAIL, BUSY, P_SAT, STATE} !== {4'b1100, 3'd4} ||
          INVU_NCONF !== 4'hF || INVD_NCONF !== 4'h0) begin
         bad++; $display("FAIL nsat n_sat=%b fail=%b busy=%b p_sat=%b state=%0d upn=%0d dnn=%0d",
                         N_SAT, FAIL, BUSY, P_SAT, STATE, INVU_NCONF, INVD_NCONF);
      end
      clk_step(0, 1, 1, 0);
      total++;
      if (STATE !== 3'd1 || {INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF} !== 16'hFF00 ||
          {DONE, FAIL, P_SAT, N_SAT} !== 4'b0000) begin
         bad++; $display("FAIL nsat_restart state=%0d codes=%h flags=%b want 1/ff00/0000", STATE,
                         {INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF}, {DONE, FAIL, P_SAT, N_SAT});
      end
   endtask

   task automatic test_start_ignored();
      clk_step(0, 0, 1, 0);
      clk_step(0, 1, 1, 0);
      clk_step(0, 0, 1, 0);
      total++;
      if (INVU_PCONF !== 4'd14 || STATE !== 3'd1) begin
         bad++; $display("FAIL start_ignored up=%0d state=%0d want 14/1", INVU_PCONF, STATE);
      end
      repeat (P) clk_step(0, 0, 1, 0);
      total++;
      if (INVU_PCONF !== 4'd13 || INVD_PCONF !== 4'd2) begin
         bad++; $display("FAIL start_ignored_next up=%0d dn=%0d want 13/2", INVU_PCONF, INVD_PCONF);
      end
   endtask

   task automatic test_reset_mid();
      repeat (P) clk_step(0, 0, 0, 1);
      repeat (P) clk_step(0, 0, 1, 0);
      repeat (P) clk_step(0, 0, 0, 1);
      total++;
      if (STATE !== 3'd2 || INVU_PCONF !== 4'd13) begin
         bad++; $display("FAIL reset_mid_entry state=%0d up=%0d want 2/13", STATE, INVU_PCONF);
      end
      clk_step(0, 0, 1, 0);
      clk_step(1, 0, 1, 0);
      total++;
      if ({INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF} !== 16'hFF00 ||
          {STATE, BUSY, DONE, FAIL, P_SAT, N_SAT} !== 8'h00) begin
         bad++; $display("FAIL reset_mid codes=%h status=%h want ff00/00",
                         {INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF},
                         {STATE, BUSY, DONE, FAIL, P_SAT, N_SAT});
      end
   endtask

   task automatic test_random();
      int mode;
      bit r, s, u, d;
      logic [23:0] got, want;
      logic [3:0]  ep, en;
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) mode = $urandom_range(0, 2);
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 9) == 0);
         if (mode != 0 && $urandom_range(0, 9) != 0) begin
            u = (mode == 1); d = (mode == 2);
         end else begin
            u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
         end
         clk_step(r, s, u, d);
         ep   = 4'(m_up_p);
         en   = 4'(m_up_n);
         want = {3'(m_state), ep, en, ~ep, ~en,
                 (m_state == 1 || m_state == 2), (m_state == 3), (m_state == 4), m_p_sat, m_n_sat};
         got  = {STATE, INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF, BUSY, DONE, FAIL, P_SAT, N_SAT};
         total++;
         if (got !== want) begin
            bad++; $display("FAIL random_c%0d got=%h want=%h", c, got, want);
         end
      end
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; O_INVU = 1'b0; O_INVD = 1'b0;
      test_reset();
      test_p_saturation();
      test_lock();
      test_invalid();
      test_n_saturation();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inv_pair_calibrator.md
Name: inv_pair_calibrator

Overview:
- Closed-loop calibrator for one up/down inverter pair. Drives four CONF_BITS-wide PMOS/NMOS strength codes (INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF) from the pair's comparator outputs O_INVU/O_INVD.
- Successor to the fixed-width config block. Adds parametrised width, an explicit P-then-N phase FSM, a settle interval between steps, lock detection by comparator polarity flips, saturation handling and status outputs.

Parameters:
- CONF_BITS, 4: width of each config code.
- SETTLE_CYCLES, 8: idle cycles after each sample before the next sample (>=1).
- LOCK_FLIPS, 3: number of comparator polarity reversals that declares a phase locked (>=1).

Ports:
- CLK  in  1  clock; all logic is posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; begins calibration.
- O_INVU  in  1  comparator, up side.
- O_INVD  in  1  comparator, down side.
- INVU_PCONF  out  CONF_BITS  up-inverter PMOS code.
- INVU_NCONF  out  CONF_BITS  up-inverter NMOS code.
- INVD_PCONF  out  CONF_BITS  down-inverter PMOS code.
- INVD_NCONF  out  CONF_BITS  down-inverter NMOS code.
- BUSY  out  1  high in CAL_P or CAL_N.
- DONE  out  1  sticky; high in DONE.
- FAIL  out  1  sticky; high in FAIL.
- P_SAT  out  1  sticky; P phase ended on saturation.
- N_SAT  out  1  sticky; N phase ended on saturation.
- STATE  out  3  IDLE=0, CAL_P=1, CAL_N=2, DONE=3, FAIL=4.

Behaviour:
- Clock and reset: one clock CLK; RST is synchronous and active-high.
- RST (any state, including mid-calibration), effective at the next edge:
  - STATE=IDLE.
  - INVU_PCONF=INVU_NCONF={CONF_BITS{1}}.
  - INVD_PCONF=INVD_NCONF=0.
  - BUSY=DONE=FAIL=P_SAT=N_SAT=0.
  - Internal settle counter=0, flip counter=0, last-polarity invalid.
- Code invariant: INVD_xCONF == ~INVU_xCONF at all times. Every step moves the up code and the down code in opposite directions by 1.
- IDLE/DONE/FAIL + START:
  - Reload codes to their reset values; clear DONE/FAIL/P_SAT/N_SAT.
  - Enter CAL_P with settle counter=SETTLE_CYCLES, flip counter=0, last-polarity invalid.
- START while BUSY is ignored.
- CAL_x (x = P or N), settle counter non-zero: decrement by 1; no sampling.
- CAL_x, settle counter zero: sample {O_INVU,O_INVD} this cycle and reload counter=SETTLE_CYCLES. Sample period is SETTLE_CYCLES+1 cycles. The first sample falls SETTLE_CYCLES+1 cycles after phase entry.
- Sample decode, applied to the phase's codes only (P codes in CAL_P, N codes in CAL_N):
  - 2'b10 (up too strong): INVU_x -1, INVD_x +1.
  - 2'b01: INVU_x +1, INVD_x -1.
  - 2'b00 / 2'b11: invalid. No step, no flip counted, last-polarity unchanged.
- Flip detection:
  - A valid sample whose polarity differs from a valid last-polarity increments the flip counter.
  - Last-polarity is then updated.
  - The first valid sample of a phase never counts as a flip.
- Priority at a valid sample:
  1. Lock: if the flip counter would reach LOCK_FLIPS, apply no step and end the phase locked.
  2. Saturation: if the step would wrap (2'b10 with INVU_x==0, or 2'b01 with INVU_x==all-ones), apply no step and end the phase saturated.
  3. Otherwise apply the step.
- Phase end:
  - CAL_P locked → CAL_N.
  - CAL_P saturated → set P_SAT, then CAL_N.
  - CAL_N locked → DONE.
  - CAL_N saturated → set N_SAT, then FAIL.
  - CAL_N entry resets the settle counter (=SETTLE_CYCLES), the flip counter and last-polarity.
  - P codes hold their final values through CAL_N, DONE and FAIL.
- Codes never change outside sample cycles. All outputs are registered.

Test Plan:
- Reset values: CONF_BITS=4. Assert RST one cycle → INVU_P/N=4'hF, INVD_P/N=4'h0, STATE=0, all flags 0.
- P saturation: SETTLE=2, hold {O_INVU,O_INVD}=10 after START.
  - INVU_PCONF steps 15→0, one step every 3 cycles, with INVD_PCONF=~INVU_PCONF throughout.
  - 16th sample → P_SAT=1, STATE=2, P codes held at 0/15.
- Lock: LOCK_FLIPS=3, samples 10,01,10,01 in CAL_P.
  - INVU_PCONF goes 15→14→15→14, and the 4th sample applies no step.
  - STATE→CAL_N with INVU_PCONF=14, P_SAT=0.
  - Same pattern in CAL_N → DONE=1, BUSY=0.
- Invalid samples: inject 11 then 00 mid-phase → codes unchanged, flip count unchanged. A following 01 after a prior 10 counts as a flip.
- N saturation: in CAL_N hold 01 → N codes unchanged (already at limit), first sample → N_SAT=1, FAIL=1, STATE=4. A subsequent START restarts from reset codes.
- Reset and START handling:
  - RST asserted during CAL_N mid-settle → next edge all reset values.
  - START pulsed during CAL_P → ignored (STATE, counters and codes unaffected).
